// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the minutes:seconds countdown timer.
// Covers the FSM state encoding, BCD constants and a decimal-to-BCD helper.
package countdown_timer_pkg;

    typedef enum logic [2:0] {
        ST_SET_MIN = 3'd0,
        ST_SET_SEC = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_ALARM   = 3'd4
    } state_t;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_00 = 8'h00;

    // Converts a decimal value in the range 0..99 into two BCD digits {tens,ones}.
    function automatic logic [7:0] to_bcd2(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/countdown_timer_bcd2_counter.sv
// Two-digit BCD up/down counter that wraps between 00 and MAX.
// borrow_out flags a decrement at 00 and wrap_out flags an increment at MAX.
module bcd2_counter
    import countdown_timer_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    output logic [7:0] value,
    output logic       borrow_out,
    output logic       wrap_out
);

    logic [7:0] value_nx;

    always_comb begin
        value_nx = value;
        if (clr) begin
            value_nx = BCD_00;
        end else if (dec) begin
            if (value == BCD_00)
                value_nx = MAX;
            else if (value[3:0] == 4'd0)
                value_nx = {value[7:4] - 4'd1, 4'd9};
            else
                value_nx = value - 8'd1;
        end else if (inc) begin
            if (value == MAX)
                value_nx = BCD_00;
            else if (value[3:0] == 4'd9)
                value_nx = {value[7:4] + 4'd1, 4'd0};
            else
                value_nx = value + 8'd1;
        end
    end

    assign borrow_out = dec & ~clr & (value == BCD_00);
    assign wrap_out   = inc & ~clr & ~dec & (value == MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= BCD_00;
        else
            value <= value_nx;
    end

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with set/run/pause/alarm FSM and 1 Hz prescaler.
// It consumes one-clock debounced key pulses and registers all of its outputs.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 27_000_000,
    parameter int unsigned MAX_MIN    = 99,
    parameter int unsigned ALARM_SECS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_start,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       edit_sec,
    output logic       blink,
    output logic       running,
    output logic       alarm
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned AW = $clog2(ALARM_SECS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

    state_t        state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [AW-1:0] acnt, acnt_nx;
    logic          tick, time_zero, time_one;
    logic          presc_clr, min_inc, sec_inc, sec_dec, time_clr, sec_borrow;
    logic          min_borrow, min_wrap, sec_wrap;

    assign tick      = (state != ST_PAUSE) && (presc == PRESC_LAST);
    assign time_zero = (min_bcd == BCD_00) && (sec_bcd == BCD_00);
    assign time_one  = (min_bcd == BCD_00) && (sec_bcd == 8'h01);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        presc_clr = 1'b0;
        min_inc   = 1'b0;
        sec_inc   = 1'b0;
        sec_dec   = 1'b0;
        time_clr  = 1'b0;
        acnt_nx   = '0;
        unique case (state)
            ST_SET_MIN, ST_SET_SEC: begin
                // start outranks mode and up even when it is ignored at 00:00
                if (key_start) begin
                    if (!time_zero) begin
                        state_nx  = ST_RUN;
                        presc_clr = 1'b1;
                    end
                end else if (key_mode) begin
                    state_nx = (state == ST_SET_MIN) ? ST_SET_SEC : ST_SET_MIN;
                end else if (key_up) begin
                    min_inc = (state == ST_SET_MIN);
                    sec_inc = (state == ST_SET_SEC);
                end
            end
            ST_RUN: begin
                sec_dec = tick;
                if (tick && time_one)
                    state_nx = ST_ALARM;
                else if (key_start)
                    state_nx = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (key_start)
                    state_nx = ST_RUN;
                else if (key_mode)
                    state_nx = ST_SET_MIN;
            end
            ST_ALARM: begin
                acnt_nx = tick ? acnt + AW'(1) : acnt;
                if (key_start || key_mode || key_up || (tick && acnt == ALARM_LAST)) begin
                    state_nx = ST_SET_MIN;
                    time_clr = 1'b1;
                end
            end
            default: state_nx = ST_SET_MIN;
        endcase

        if (presc_clr || tick)
            presc_nx = '0;
        else if (state == ST_PAUSE)
            presc_nx = presc;
        else
            presc_nx = presc + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_SET_MIN;
            presc    <= '0;
            acnt     <= '0;
            running  <= 1'b0;
            alarm    <= 1'b0;
            edit_sec <= 1'b0;
            blink    <= 1'b0;
        end else begin
            state    <= state_nx;
            presc    <= presc_nx;
            acnt     <= acnt_nx;
            running  <= (state_nx == ST_RUN);
            alarm    <= (state_nx == ST_ALARM);
            edit_sec <= (state_nx == ST_SET_SEC);
            blink    <= ((state_nx == ST_SET_MIN) || (state_nx == ST_SET_SEC))
                        && (presc_nx >= PRESC_HALF);
        end
    end

    // Minutes only ever move down through the seconds borrow.
    bcd2_counter #(.MAX(to_bcd2(MAX_MIN))) u_min (
        .clk       (clk),
        .rst       (rst),
        .inc       (min_inc),
        .dec       (sec_borrow),
        .clr       (time_clr),
        .value     (min_bcd),
        .borrow_out(min_borrow),
        .wrap_out  (min_wrap)
    );

    bcd2_counter #(.MAX(BCD_59)) u_sec (
        .clk       (clk),
        .rst       (rst),
        .inc       (sec_inc),
        .dec       (sec_dec),
        .clr       (time_clr),
        .value     (sec_bcd),
        .borrow_out(sec_borrow),
        .wrap_out  (sec_wrap)
    );

endmodule
